// File: rtl/tb_seq_pkg.sv
// Shared types for the test sequencer: FSM state encoding, run status codes
// and the default length of the datapath flush at run start.
package tb_seq_pkg;

  localparam int FLUSH_CYCLES_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FLUSH  = 3'd1,
    ST_ENABLE = 3'd2,
    ST_SETTLE = 3'd3,
    ST_SAMPLE = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    STAT_NONE       = 2'd0,
    STAT_PASS       = 2'd1,
    STAT_FAIL_LIMIT = 2'd2,
    STAT_ABORTED    = 2'd3
  } status_e;

endpackage

// File: rtl/test_sequencer.sv
// Run sequencer for the randomiser/driver/monitor/scoreboard test wrapper.
// Optional error-limit stop is compiled in with SEQ_ERR_LIMIT_EN.
//
// state  | meaning
// IDLE   | no run yet; datapath held in reset
// FLUSH  | datapath reset for FLUSH_CYCLES cycles
// ENABLE | one-cycle randomiser advance
// SETTLE | wait latched settle cycles for the DUT
// SAMPLE | one-cycle monitor capture, counters update
// DONE   | run finished, status valid until next start
module test_sequencer
  import tb_seq_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_num_vectors,
  input  logic [7:0]       i_settle_cycles,
  input  logic             i_event,
`ifdef SEQ_ERR_LIMIT_EN
  input  logic [WIDTH-1:0] i_err_limit,
`endif
  output logic             o_tb_reset,
  output logic             o_tb_enable,
  output logic             o_sample,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_vec_ctr,
  output logic [WIDTH-1:0] o_err_ctr,
  output logic [1:0]       o_status
);

  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  state_e           state_q, state_d;
  status_e          status_q, status_d;
  logic [3:0]       flush_q, flush_d;
  logic [7:0]       wait_q, wait_d;
  logic [7:0]       settle_q, settle_d;
  logic [WIDTH-1:0] num_q, num_d;
  logic [WIDTH-1:0] vec_q, vec_d;
  logic [WIDTH-1:0] err_q, err_d;
`ifdef SEQ_ERR_LIMIT_EN
  logic [WIDTH-1:0] limit_q, limit_d;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      status_q <= STAT_NONE;
      flush_q  <= '0;
      wait_q   <= '0;
      settle_q <= '0;
      num_q    <= '0;
      vec_q    <= '0;
      err_q    <= '0;
`ifdef SEQ_ERR_LIMIT_EN
      limit_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      flush_q  <= flush_d;
      wait_q   <= wait_d;
      settle_q <= settle_d;
      num_q    <= num_d;
      vec_q    <= vec_d;
      err_q    <= err_d;
`ifdef SEQ_ERR_LIMIT_EN
      limit_q  <= limit_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    flush_d  = flush_q;
    wait_d   = wait_q;
    settle_d = settle_q;
    num_d    = num_q;
    vec_d    = vec_q;
    err_d    = err_q;
`ifdef SEQ_ERR_LIMIT_EN
    limit_d  = limit_q;
`endif
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          state_d  = ST_FLUSH;
          status_d = STAT_NONE;
          flush_d  = FLUSH_LAST;
          num_d    = i_num_vectors;
          settle_d = i_settle_cycles;
          vec_d    = '0;
          err_d    = '0;
`ifdef SEQ_ERR_LIMIT_EN
          limit_d  = i_err_limit;
`endif
        end
      end
      ST_FLUSH: begin
        if (i_abort) begin
          state_d  = ST_DONE;
          status_d = STAT_ABORTED;
        end else if (flush_q == 4'd0) begin
          if (num_q == '0) begin
            state_d  = ST_DONE;
            status_d = STAT_PASS;
          end else begin
            state_d = ST_ENABLE;
          end
        end else begin
          flush_d = flush_q - 4'd1;
        end
      end
      ST_ENABLE: begin
        wait_d = settle_q - 8'd1;
        if (i_abort) begin
          state_d  = ST_DONE;
          status_d = STAT_ABORTED;
        end else if (settle_q == 8'd0) begin
          state_d = ST_SAMPLE;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (i_abort) begin
          state_d  = ST_DONE;
          status_d = STAT_ABORTED;
        end else if (wait_q == 8'd0) begin
          state_d = ST_SAMPLE;
        end else begin
          wait_d = wait_q - 8'd1;
        end
      end
      ST_SAMPLE: begin
        // The sample is committed even when the run is aborted this cycle.
        vec_d = vec_q + WIDTH'(1);
        if (i_event && (err_q != '1)) begin
          err_d = err_q + WIDTH'(1);
        end
        if (i_abort) begin
          state_d  = ST_DONE;
          status_d = STAT_ABORTED;
        end
`ifdef SEQ_ERR_LIMIT_EN
        else if ((limit_q != '0) && (err_d >= limit_q)) begin
          state_d  = ST_DONE;
          status_d = STAT_FAIL_LIMIT;
        end
`endif
        else if (vec_d == num_q) begin
          state_d  = ST_DONE;
          status_d = STAT_PASS;
        end else begin
          state_d = ST_ENABLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_tb_reset  = (state_q == ST_IDLE) || (state_q == ST_FLUSH);
  assign o_tb_enable = (state_q == ST_ENABLE);
  assign o_sample    = (state_q == ST_SAMPLE);
  assign o_busy      = (state_q == ST_FLUSH) || (state_q == ST_ENABLE) ||
                       (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign o_done      = (state_q == ST_DONE);
  assign o_vec_ctr   = vec_q;
  assign o_err_ctr   = err_q;
  assign o_status    = status_q;

endmodule

// File: tb/tb_test_sequencer.sv
// Scoreboard bench for test_sequencer: a cycle-arithmetic run model pushes expected
// sample and completion records; a monitor pops and compares them as the DUT strobes.
module tb_test_sequencer;

  localparam int W = 32;
  localparam int F = 2;
  localparam int EV_DEPTH = 65536;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         i_start = 1'b0;
  logic         i_abort = 1'b0;
  logic [W-1:0] i_num_vectors = '0;
  logic [7:0]   i_settle_cycles = '0;
  logic         i_event = 1'b0;
  logic [W-1:0] i_err_limit = '0;
  logic         o_tb_reset, o_tb_enable, o_sample, o_busy, o_done;
  logic [W-1:0] o_vec_ctr, o_err_ctr;
  logic [1:0]   o_status;

  test_sequencer #(.WIDTH(W), .FLUSH_CYCLES(F)) dut (
    .clk             (clk),
    .reset           (reset),
    .i_start         (i_start),
    .i_abort         (i_abort),
    .i_num_vectors   (i_num_vectors),
    .i_settle_cycles (i_settle_cycles),
    .i_event         (i_event),
`ifdef SEQ_ERR_LIMIT_EN
    .i_err_limit     (i_err_limit),
`endif
    .o_tb_reset      (o_tb_reset),
    .o_tb_enable     (o_tb_enable),
    .o_sample        (o_sample),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_vec_ctr       (o_vec_ctr),
    .o_err_ctr       (o_err_ctr),
    .o_status        (o_status)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int c; int vec; int err;} samp_t;
  typedef struct {int c; int status; int vec; int err; int enables; int flushes;} done_t;

  samp_t sq[$];
  done_t dq[$];
  bit    ev_mem [EV_DEPTH];
  int    n_vec  = 0;
  int    n_miss = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // i_event applied during the cycle numbered cyc comes from the pre-planned table
  initial forever begin
    @(negedge clk);
    i_event = (cyc < EV_DEPTH) ? ev_mem[cyc] : 1'b0;
  end

  // Monitor: consumes scoreboard records whenever the DUT strobes
  initial begin
    bit busy_p = 0, done_p = 0;
    int en_cnt = 0, fl_cnt = 0;
    samp_t s;
    done_t d;
    forever begin
      @(posedge clk);
      #1;
      if (o_busy && !busy_p) begin
        en_cnt = 0;
        fl_cnt = 0;
      end
      if (o_tb_enable) en_cnt++;
      if (o_tb_reset && o_busy) fl_cnt++;
      if (o_sample) begin
        if (sq.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL sample_unexpected @cyc %0d: got o_sample=1, expected none", cyc);
        end else begin
          s = sq.pop_front();
          chk("sample_cycle", cyc, s.c);
          chk("sample_vec_before", o_vec_ctr, s.vec);
          chk("sample_err_before", o_err_ctr, s.err);
        end
      end
      if (o_done && !done_p) begin
        if (dq.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL done_unexpected @cyc %0d: got o_done=1, expected none", cyc);
        end else begin
          d = dq.pop_front();
          chk("done_cycle", cyc, d.c);
          chk("done_status", o_status, d.status);
          chk("done_vec", o_vec_ctr, d.vec);
          chk("done_err", o_err_ctr, d.err);
          chk("done_enables", en_cnt, d.enables);
          chk("done_flush_cycles", fl_cnt, d.flushes);
          chk("done_busy_low", o_busy, 0);
        end
      end
      busy_p = o_busy;
      done_p = o_done;
    end
  end

  // Called at a negedge: plans events, predicts the run from cycle arithmetic,
  // pushes expectations and raises i_start for the coming edge.
  task automatic issue(input int n, input int settle, input int limit, input int ev_mode,
                       input int abort_off, output int s, output int d, output int st);
    int p, vec, err, en, fl, ac, eff_limit, t;
    bit fin;
    s = cyc;
    p = settle + 2;
    for (int c = s + 1; c <= s + F + n * p + 2 && c < EV_DEPTH; c++)
      ev_mem[c] = (ev_mode == 2) ? 1'b1 : (ev_mode == 1) ? 1'b0 : ($urandom_range(0, 2) == 0);
`ifdef SEQ_ERR_LIMIT_EN
    eff_limit = limit;
`else
    eff_limit = 0;
`endif
    ac  = (abort_off < 0) ? -1 : s + abort_off;
    vec = 0; err = 0; en = 0; fl = F; fin = 0; d = 0; st = 0;
    if (ac >= 0 && ac <= s + F) begin
      fl = ac - s; d = ac + 1; st = 3; fin = 1;
    end else if (n == 0) begin
      d = s + F + 1; st = 1; fin = 1;
    end
    for (int k = 1; k <= n && !fin; k++) begin
      t = s + F + k * p;
      en++;
      if (ac >= 0 && ac < t) begin
        d = ac + 1; st = 3; fin = 1;
      end else begin
        sq.push_back('{t, vec, err});
        vec++;
        if (ev_mem[t]) err++;
        if (ac == t) begin
          d = t + 1; st = 3; fin = 1;
        end else if (eff_limit != 0 && err >= eff_limit) begin
          d = t + 1; st = 2; fin = 1;
        end else if (vec == n) begin
          d = t + 1; st = 1; fin = 1;
        end
      end
    end
    dq.push_back('{d, st, vec, err, en, fl});
    i_num_vectors   = n;
    i_settle_cycles = 8'(settle);
    i_err_limit     = limit;
    i_start         = 1'b1;
  endtask

  task automatic run(input int n, input int settle, input int limit, input int ev_mode,
                     input int abort_off, input bit junk, input bit sim_start);
    int s, d, st, ac;
    @(negedge clk);
    issue(n, settle, limit, ev_mode, abort_off, s, d, st);
    @(negedge clk);
    i_start         = 1'b0;
    i_num_vectors   = $urandom;
    i_settle_cycles = 8'($urandom);
    i_err_limit     = $urandom;
    ac = (abort_off < 0) ? -1 : s + abort_off;
    while (cyc < d) begin
      i_abort = (cyc == ac);
      i_start = (sim_start && cyc == ac) || (junk && $urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    i_start = 1'b0;
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    chk("done_held_after_idle_abort", o_done, 1);
    chk("status_held_after_idle_abort", o_status, st);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tb_reset"}, o_tb_reset, 1);
    chk({tag, "_tb_enable"}, o_tb_enable, 0);
    chk({tag, "_sample"}, o_sample, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_vec"}, o_vec_ctr, 0);
    chk({tag, "_err"}, o_err_ctr, 0);
    chk({tag, "_status"}, o_status, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog @cyc %0d: got no completion, expected finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s, d, st, lim;
    repeat (3) @(negedge clk);
    check_reset_outputs("in_reset");
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("idle");

    run(4, 3, 0, 1, -1, 0, 0);
    run(0, 4, 0, 0, -1, 0, 0);
    run(10, 0, 3, 2, -1, 0, 0);
    run(100, 5, 0, 0, 20, 1, 0);
    run(3, 1, 0, 0, -1, 0, 0);

    // Reset mid-SETTLE after one counted sample with an event
    @(negedge clk);
    issue(5, 2, 0, 2, -1, s, d, st);
    @(negedge clk);
    i_start = 1'b0;
    while (cyc < s + F + 6) @(negedge clk);
    chk("pre_reset_vec", o_vec_ctr, 1);
    reset = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    sq.delete();
    dq.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    run(2, 3, 0, 0, -1, 0, 0);

    run(6, 4, 0, 0, 9, 0, 1);
    run(2, 1, 0, 0, -1, 0, 0);
    run(5, 0, 0, 0, F + 2, 0, 0);
    run(3, 2, 0, 0, 1, 0, 0);

    for (int i = 0; i < 24; i++) begin
      int n, st_c, ab;
      n    = $urandom_range(0, 12);
      st_c = $urandom_range(0, 6);
      lim  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 5);
      ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, F + n * (st_c + 2)) : -1;
      run(n, st_c, lim, 0, ab, 1, 0);
    end

    repeat (3) @(negedge clk);
    chk("sample_queue_drained", sq.size(), 0);
    chk("done_queue_drained", dq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
